// File: rtl/ks_wide_add_seq.sv
// ks_wide_add_seq
//
// Multi-cycle sequencer that performs a WORDS x 16-bit add or subtract by
// driving an external combinational 16-bit adder one slice per cycle, least
// significant slice first, and chaining the carry through a register.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Once out_valid rises it stays high, with S,
// Co and ovf stable, until the edge at which out_ready is seen high.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready request handshake; A, B, ci, sub sampled at accept
//   A, B              N-bit operands (N = 16*WORDS)
//   ci                carry-in; for sub=1 it is the borrow-in
//   sub               1: S = A - B - ci, 0: S = A + B + ci
//   out_valid/out_ready result handshake
//   S, Co, ovf        N-bit result, MSB carry-out (sub: 1 = no borrow),
//                     signed two's-complement overflow
//   add_a/add_b/add_ci slice operands to the external adder (0 when idle)
//   add_s/add_co      same-cycle sum and carry returned by the adder
module ks_wide_add_seq #(
  parameter int WORDS = 4,
  localparam int N = 16 * WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          ci,
  input  logic          sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  S,
  output logic          Co,
  output logic          ovf,
  output logic [15:0]   add_a,
  output logic [15:0]   add_b,
  output logic          add_ci,
  input  logic [15:0]   add_s,
  input  logic          add_co
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;     // B already inverted for subtraction
  logic           carry_q, carry_d;
  logic [N-1:0]   s_q, s_d;
  logic           co_q, co_d;
  logic           ovf_q, ovf_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    s_d       = s_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_ci    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d = A;
          // Subtraction is A + ~B + 1 - borrow, so the initial carry is ci ^ sub.
          b_d     = sub ? ~B : B;
          carry_d = ci ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        add_a  = a_q[16*idx_q +: 16];
        add_b  = b_q[16*idx_q +: 16];
        add_ci = carry_q;
        s_d[16*idx_q +: 16] = add_s;
        carry_d = add_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          co_d = add_co;
          // Overflow: both effective operands share a sign that the sum lacks.
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[15] != a_q[N-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S   = s_q;
  assign Co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_ks_wide_add_seq.sv
// Testbench for ks_wide_add_seq (WORDS = 4, N = 64).
// The external 16-bit adder is modelled behaviourally here. Expected
// results {ovf, Co, S} come from whole-width arithmetic on the request
// and are queued at each accept; a monitor pops on every output transfer.
module tb_ks_wide_add_seq;

  localparam int WORDS = 4;
  localparam int N = 16 * WORDS;
  localparam int RW = N + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          ci;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  S;
  logic          Co;
  logic          ovf;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_ci;
  logic [15:0]   add_s;
  logic          add_co;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];
  logic          ci_trace [WORDS];

  ks_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co),
    .ovf       (ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  // Behavioural 16-bit adder standing in for koggestone16.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_ci};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {ovf, Co, S} from plain whole-width arithmetic.
  function automatic logic [RW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic c, input logic s);
    logic [N:0]           wide;
    logic signed [RW-1:0] sa, sb, sc, sv, hi, lo;
    logic                 co_m, ovf_m;
    sa = {{2{a[N-1]}}, a};
    sb = {{2{b[N-1]}}, b};
    sc = {{(RW-1){1'b0}}, c};
    hi = {3'b000, {(N-1){1'b1}}};
    lo = {3'b111, {(N-1){1'b0}}};
    if (!s) begin
      wide = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
      co_m = wide[N];
      sv   = sa + sb + sc;
    end else begin
      wide = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, c};
      // No borrow when A >= B + borrow-in.
      co_m = ({1'b0, a} >= ({1'b0, b} + {{N{1'b0}}, c}));
      sv   = sa - sb - sc;
    end
    ovf_m = (sv > hi) || (sv < lo);
    return {ovf_m, co_m, wide[N-1:0]};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic s);
    @(posedge clk);
    #1;
    A = a; B = b; ci = c; sub = s;
    in_valid = 1'b1;
  endtask

  // Waits until the request is accepted, pushing its expected response.
  task automatic wait_accept(output int nw);
    nw = -1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready && in_valid) begin
        exp_q.push_back(model(A, B, ci, sub));
        nw = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 1'b0, 1'b1);
  endtask

  // Records add_ci for each slice and returns how many edges after the
  // accept edge out_valid is first seen high.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k < WORDS) ci_trace[k] = add_ci;
      if (out_valid) begin
        lat = k;
        return;
      end
    end
    check("result_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input logic s, output int lat);
    int nw;
    issue(a, b, c, s);
    wait_accept(nw);
    wait_result(lat);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %h with no request outstanding", {ovf, Co, S});
        end else begin
          e = exp_q.pop_front();
          check("result", {ovf, Co, S}, e);
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int lat;
    int nw;
    logic [RW-1:0] e;
    logic [N-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", {ovf, Co, S}, '0);
    check("reset_adder_ports", {add_a, add_b, add_ci}, '0);

    // 1: carry out of slice 0 into slice 1.
    run_one(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
    check("t1_latency", lat, WORDS);
    check("t1_ci_slices01", {ci_trace[0], ci_trace[1]}, 2'b01);
    check("t1_expected", {1'b0, 1'b0, 64'h0000_0000_0001_0000},
          model(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0));

    // 2: ripple through all slices, wrap to zero.
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    check("t2_latency", lat, WORDS);
    check("t2_ci_slices", {ci_trace[0], ci_trace[1], ci_trace[2], ci_trace[3]}, 4'b0111);

    // 3: signed overflow.
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    check("t3_latency", lat, WORDS);

    // 4: subtraction with and without borrow.
    run_one(64'h5, 64'h7, 1'b0, 1'b1, lat);
    check("t4a_latency", lat, WORDS);
    run_one(64'h7, 64'h5, 1'b0, 1'b1, lat);
    check("t4b_latency", lat, WORDS);

    // 5: backpressure with a competing request held at the input.
    @(posedge clk); #1 out_ready = 1'b0;
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    run_one(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, lat);
    check("t5_latency", lat, WORDS);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; in_valid = 1'b1;
      @(negedge clk);
      check("t5_hold_result", {ovf, Co, S}, e);
      check("t5_hold_in_ready", in_ready, 1'b0);
      check("t5_hold_out_valid", out_valid, 1'b1);
    end
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_release_out_valid", out_valid, 1'b0);
    check("t5_release_in_ready", in_ready, 1'b1);
    wait_accept(nw);
    check("t5_queued_accept_wait", nw, 0);
    wait_result(lat);
    check("t5_queued_latency", lat, WORDS);

    // 6: reset during RUN slice 2; the aborted request is never presented.
    issue(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    wait_accept(nw);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_result_cleared", {ovf, Co, S}, '0);
    check("t6_adder_ports", {add_a, add_b, add_ci}, '0);
    repeat (8) @(negedge clk);
    run_one(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b1, lat);
    check("t6_next_latency", lat, WORDS);

    // Random requests with occasional output stalls.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = {$urandom, $urandom}; rb = ra; end
        1: begin ra = {N{1'b1}}; rb = {$urandom, $urandom}; end
        2: begin ra = {48'h0, 16'($urandom)}; rb = {48'h0, 16'($urandom)}; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0);
      run_one(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat);
      check("rand_latency", lat, WORDS);
      if (!out_ready) begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
      end
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
